bcd_4d_seg_scan: RTL and testbench

Time-multiplexed 4-digit seven-segment display driver that sits directly downstream of the 4-digit BCD counter and consumes its packed 16-bit BCD value. A prescaler sets the digit dwell time. A digit index scans digits 0→3. The BCD word and decimal points are snapshotted once per frame, so a count change mid-scan never shows a mixed value. Optional leading-zero blanking applies, and nibbles above 9 display as a dash.

---
 rtl/seg7_pkg.sv | 44 ++++
 rtl/seg7_decode.sv | 13 +
 rtl/bcd_4d_seg_scan.sv | 120 ++++++++++++
 tb/tb_bcd_4d_seg_scan.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-high segment codes {g,f,e,d,c,b,a},
// the digit-slot enum and the nibble decode used by the scan driver.
package seg7_pkg;

   localparam logic [6:0] SEG_0    = 7'h3F;
   localparam logic [6:0] SEG_1    = 7'h06;
   localparam logic [6:0] SEG_2    = 7'h5B;
   localparam logic [6:0] SEG_3    = 7'h4F;
   localparam logic [6:0] SEG_4    = 7'h66;
   localparam logic [6:0] SEG_5    = 7'h6D;
   localparam logic [6:0] SEG_6    = 7'h7D;
   localparam logic [6:0] SEG_7    = 7'h07;
   localparam logic [6:0] SEG_8    = 7'h7F;
   localparam logic [6:0] SEG_9    = 7'h6F;
   localparam logic [6:0] SEG_DASH = 7'h40;
   localparam logic [6:0] SEG_OFF  = 7'h00;

   typedef enum logic [1:0] {
      DIG_0 = 2'd0,
      DIG_1 = 2'd1,
      DIG_2 = 2'd2,
      DIG_3 = 2'd3
   } digit_e;

   // Non-BCD nibbles render as a dash so a corrupted count is visible.
   function automatic logic [6:0] seg7_code(input logic [3:0] nib);
      logic [6:0] code;
      case (nib)
         4'd0:    code = SEG_0;
         4'd1:    code = SEG_1;
         4'd2:    code = SEG_2;
         4'd3:    code = SEG_3;
         4'd4:    code = SEG_4;
         4'd5:    code = SEG_5;
         4'd6:    code = SEG_6;
         4'd7:    code = SEG_7;
         4'd8:    code = SEG_8;
         4'd9:    code = SEG_9;
         default: code = SEG_DASH;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to active-high seven-segment code.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nib_i,
   output logic [6:0] code_o
);

   always_comb begin
      code_o = seg7_code(nib_i);
   end

endmodule

// File: rtl/bcd_4d_seg_scan.sv
// Four-digit multiplexed seven-segment driver with per-frame snapshot of the
// BCD word and decimal points, optional leading-zero blanking and output polarity.
module bcd_4d_seg_scan
   import seg7_pkg::*;
#(
   parameter int unsigned SCAN_DIV       = 50000,
   parameter bit          SEG_ACTIVE_LOW = 1'b1,
   parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic [15:0] bcd,
   input  logic [3:0]  dp,
   input  logic        lzb,
   output logic [7:0]  seg,
   output logic [3:0]  an
);

   localparam int unsigned         DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [7:0]          SEG_INV  = {8{SEG_ACTIVE_LOW}};
   localparam logic [3:0]          AN_INV   = {4{AN_ACTIVE_LOW}};

   logic [DIV_W-1:0] div_q, div_d;
   digit_e           idx_q, idx_d;
   logic [15:0]      snap_q;
   logic [3:0]       dps_q;
   logic [7:0]       seg_q, seg_d;
   logic [3:0]       an_q, an_d;

   logic             snap_load;
   logic [3:0]       nib;
   logic             dp_bit;
   logic             blank;
   logic [6:0]       code;
   logic             z3, z32, z321;

   always_comb begin
      div_d = div_q + DIV_W'(1);
      idx_d = idx_q;
      if (div_q == DIV_LAST) begin
         div_d = '0;
         idx_d = digit_e'(idx_q + 2'd1);
      end
      snap_load = (div_q == '0) && (idx_q == DIG_0);
   end

   // A digit is blanked only when it and every more significant digit are zero.
   always_comb begin
      z3   = (snap_q[15:12] == 4'd0);
      z32  = z3  && (snap_q[11:8] == 4'd0);
      z321 = z32 && (snap_q[7:4]  == 4'd0);
      nib    = snap_q[3:0];
      dp_bit = dps_q[0];
      blank  = 1'b0;
      case (idx_q)
         DIG_0: begin
            nib    = snap_q[3:0];
            dp_bit = dps_q[0];
            blank  = 1'b0;
         end
         DIG_1: begin
            nib    = snap_q[7:4];
            dp_bit = dps_q[1];
            blank  = lzb && z321;
         end
         DIG_2: begin
            nib    = snap_q[11:8];
            dp_bit = dps_q[2];
            blank  = lzb && z32;
         end
         DIG_3: begin
            nib    = snap_q[15:12];
            dp_bit = dps_q[3];
            blank  = lzb && z3;
         end
         default: begin
            nib    = snap_q[3:0];
            dp_bit = dps_q[0];
            blank  = 1'b0;
         end
      endcase
   end

   seg7_decode u_decode (
      .nib_i  (nib),
      .code_o (code)
   );

   always_comb begin
      seg_d = blank ? {1'b0, SEG_OFF} : {dp_bit, code};
      seg_d = seg_d ^ SEG_INV;
      an_d  = (4'b0001 << idx_q) ^ AN_INV;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_q  <= '0;
         idx_q  <= DIG_0;
         snap_q <= '0;
         dps_q  <= '0;
         seg_q  <= SEG_INV;
         an_q   <= AN_INV;
      end else if (en) begin
         div_q <= div_d;
         idx_q <= idx_d;
         seg_q <= seg_d;
         an_q  <= an_d;
         if (snap_load) begin
            snap_q <= bcd;
            dps_q  <= dp;
         end
      end
   end

   assign seg = seg_q;
   assign an  = an_q;

endmodule

// File: tb/tb_bcd_4d_seg_scan.sv
// Directed self-checking bench for bcd_4d_seg_scan with three parameterisations.
module tb_bcd_4d_seg_scan;

   logic        clk;
   logic        reset;
   logic        en;
   logic [15:0] bcd;
   logic [3:0]  dp;
   logic        lzb;
   logic [7:0]  seg_a, seg_p, seg_s;
   logic [3:0]  an_a, an_p, an_s;

   int unsigned checks;
   int unsigned failures;

   bcd_4d_seg_scan #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)) u_dut (
      .clk(clk), .reset(reset), .en(en), .bcd(bcd), .dp(dp), .lzb(lzb),
      .seg(seg_a), .an(an_a)
   );

   bcd_4d_seg_scan #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) u_pol (
      .clk(clk), .reset(reset), .en(en), .bcd(bcd), .dp(dp), .lzb(lzb),
      .seg(seg_p), .an(an_p)
   );

   bcd_4d_seg_scan #(.SCAN_DIV(1), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)) u_div1 (
      .clk(clk), .reset(reset), .en(en), .bcd(bcd), .dp(dp), .lzb(lzb),
      .seg(seg_s), .an(an_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      en    = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      en    = 1'b1;
   endtask

   task automatic test_reset_scan();
      logic [7:0] pat [4];
      logic [7:0] es;
      logic [3:0] ea;
      int unsigned d;
      pat = '{8'h66, 8'h4F, 8'h5B, 8'h06};
      bcd = 16'h1234; dp = 4'b0000; lzb = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if (seg_a !== 8'h00) begin
         failures++;
         $display("FAIL reset_seg got %h exp 00", seg_a);
      end
      checks++;
      if (an_a !== 4'h0) begin
         failures++;
         $display("FAIL reset_an got %h exp 0", an_a);
      end
      @(negedge clk);
      reset = 1'b0;
      en    = 1'b1;
      for (int n = 1; n <= 33; n++) begin
         step();
         d  = ((n - 1) / 4) % 4;
         ea = 4'b0001 << d;
         es = (n == 1) ? 8'h3F : pat[d];
         checks++;
         if (an_a !== ea || seg_a !== es) begin
            failures++;
            $display("FAIL scan edge=%0d an got %h exp %h seg got %h exp %h", n, an_a, ea, seg_a, es);
         end
      end
   endtask

   task automatic test_lzb();
      logic [7:0] es;
      logic [3:0] ea;
      bcd = 16'h0070; dp = 4'b1111; lzb = 1'b1;
      do_reset();
      for (int n = 1; n <= 32; n++) begin
         step();
         ea = 4'b0001 << (((n - 1) / 4) % 4);
         if (n == 1)       es = 8'h3F;
         else if (n <= 4)  es = 8'hBF;
         else if (n <= 8)  es = 8'h87;
         else if (n <= 16) es = 8'h00;
         else if (n <= 20) es = 8'hBF;
         else              es = 8'h00;
         checks++;
         if (an_a !== ea || seg_a !== es) begin
            failures++;
            $display("FAIL lzb edge=%0d an got %h exp %h seg got %h exp %h", n, an_a, ea, seg_a, es);
         end
         if (n == 16) bcd = 16'h0000;
      end
      lzb = 1'b0; dp = 4'b0000;
   endtask

   task automatic test_snapshot();
      logic [7:0] es;
      logic [3:0] ea;
      bcd = 16'h1234; dp = 4'b0000; lzb = 1'b0;
      do_reset();
      for (int n = 1; n <= 32; n++) begin
         step();
         ea = 4'b0001 << (((n - 1) / 4) % 4);
         if (n == 1)       es = 8'h3F;
         else if (n <= 4)  es = 8'h66;
         else if (n <= 8)  es = 8'h4F;
         else if (n <= 12) es = 8'h5B;
         else if (n <= 16) es = 8'h06;
         else if (n == 17) es = 8'h66;
         else if (n <= 20) es = 8'h7F;
         else if (n <= 24) es = 8'h07;
         else if (n <= 28) es = 8'h7D;
         else              es = 8'h6D;
         checks++;
         if (an_a !== ea || seg_a !== es) begin
            failures++;
            $display("FAIL snapshot edge=%0d an got %h exp %h seg got %h exp %h", n, an_a, ea, seg_a, es);
         end
         if (n == 10) bcd = 16'h5678;
      end
   endtask

   task automatic test_invalid_dp();
      logic [7:0] es;
      logic [3:0] ea;
      bcd = 16'h00A9; dp = 4'b0010; lzb = 1'b0;
      do_reset();
      for (int n = 1; n <= 16; n++) begin
         step();
         ea = 4'b0001 << ((n - 1) / 4);
         if (n == 1)      es = 8'h3F;
         else if (n <= 4) es = 8'h6F;
         else if (n <= 8) es = 8'hC0;
         else             es = 8'h3F;
         checks++;
         if (an_a !== ea || seg_a !== es) begin
            failures++;
            $display("FAIL invalid_dp edge=%0d an got %h exp %h seg got %h exp %h", n, an_a, ea, seg_a, es);
         end
      end
      dp = 4'b0000;
   endtask

   task automatic test_freeze_reset();
      bcd = 16'h1234; dp = 4'b0000; lzb = 1'b0;
      do_reset();
      for (int n = 1; n <= 6; n++) step();
      checks++;
      if (an_a !== 4'h2 || seg_a !== 8'h4F) begin
         failures++;
         $display("FAIL pre_freeze an got %h exp 2 seg got %h exp 4f", an_a, seg_a);
      end
      en = 1'b0;
      for (int n = 1; n <= 7; n++) begin
         step();
         checks++;
         if (an_a !== 4'h2 || seg_a !== 8'h4F) begin
            failures++;
            $display("FAIL freeze cyc=%0d an got %h exp 2 seg got %h exp 4f", n, an_a, seg_a);
         end
      end
      en = 1'b1;
      for (int n = 7; n <= 9; n++) begin
         step();
         checks++;
         if (n < 9 && (an_a !== 4'h2 || seg_a !== 8'h4F)) begin
            failures++;
            $display("FAIL resume edge=%0d an got %h exp 2 seg got %h exp 4f", n, an_a, seg_a);
         end else if (n == 9 && (an_a !== 4'h4 || seg_a !== 8'h5B)) begin
            failures++;
            $display("FAIL resume edge=%0d an got %h exp 4 seg got %h exp 5b", n, an_a, seg_a);
         end
      end
      #3;
      reset = 1'b1;
      #1;
      checks++;
      if (an_a !== 4'h0 || seg_a !== 8'h00) begin
         failures++;
         $display("FAIL async_reset an got %h exp 0 seg got %h exp 00", an_a, seg_a);
      end
      @(negedge clk);
      reset = 1'b0;
      step();
      checks++;
      if (an_a !== 4'h1 || seg_a !== 8'h3F) begin
         failures++;
         $display("FAIL restart_e1 an got %h exp 1 seg got %h exp 3f", an_a, seg_a);
      end
      step();
      checks++;
      if (an_a !== 4'h1 || seg_a !== 8'h66) begin
         failures++;
         $display("FAIL restart_e2 an got %h exp 1 seg got %h exp 66", an_a, seg_a);
      end
   endtask

   task automatic test_polarity();
      bcd = 16'h0008; dp = 4'b0000; lzb = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if (seg_p !== 8'hFF || an_p !== 4'hF) begin
         failures++;
         $display("FAIL pol_reset seg got %h exp ff an got %h exp f", seg_p, an_p);
      end
      @(negedge clk);
      reset = 1'b0;
      en    = 1'b1;
      step();
      checks++;
      if (seg_p !== 8'hC0 || an_p !== 4'hE) begin
         failures++;
         $display("FAIL pol_e1 seg got %h exp c0 an got %h exp e", seg_p, an_p);
      end
      for (int n = 2; n <= 4; n++) begin
         step();
         checks++;
         if (seg_p !== 8'h80 || an_p !== 4'hE) begin
            failures++;
            $display("FAIL pol_digit0 edge=%0d seg got %h exp 80 an got %h exp e", n, seg_p, an_p);
         end
      end
      step();
      checks++;
      if (seg_p !== 8'hC0 || an_p !== 4'hD) begin
         failures++;
         $display("FAIL pol_digit1 seg got %h exp c0 an got %h exp d", seg_p, an_p);
      end
   endtask

   task automatic test_div1();
      logic [7:0] pat [4];
      logic [7:0] es;
      logic [3:0] ea;
      pat = '{8'h66, 8'h4F, 8'h5B, 8'h06};
      bcd = 16'h1234; dp = 4'b0000; lzb = 1'b0;
      do_reset();
      for (int n = 1; n <= 8; n++) begin
         step();
         ea = 4'b0001 << ((n - 1) % 4);
         es = (n == 1) ? 8'h3F : pat[(n - 1) % 4];
         checks++;
         if (an_s !== ea || seg_s !== es) begin
            failures++;
            $display("FAIL div1 edge=%0d an got %h exp %h seg got %h exp %h", n, an_s, ea, seg_s, es);
         end
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b0;
      en       = 1'b0;
      bcd      = 16'h0000;
      dp       = 4'b0000;
      lzb      = 1'b0;
      test_reset_scan();
      test_lzb();
      test_snapshot();
      test_invalid_dp();
      test_freeze_reset();
      test_polarity();
      test_div1();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
